// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler: arbitrates N requesters onto one resource, offers the
// winner over valid/ready, then holds ownership until done.
module rr_grant_scheduler #(
  parameter int unsigned N    = 256,
  parameter int unsigned IDXW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic            gnt_valid,
  input  logic            gnt_ready,
  output logic [IDXW-1:0] gnt_idx,
  output logic [N-1:0]    gnt_onehot,
  input  logic            done,
  output logic            busy,
  output logic            any_req
);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

  state_t          state, state_nx;
  logic [IDXW-1:0] ptr, ptr_nx;
  logic [IDXW-1:0] idx_q, idx_nx;
  logic [N-1:0]    oh_q, oh_nx;
  logic            any_q;
  logic [N-1:0]    hi_mask;
  logic [N-1:0]    hi_req;
  logic [IDXW-1:0] win_idx;

  function automatic logic [IDXW-1:0] lowest_set(input logic [N-1:0] v);
    logic found;
    lowest_set = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (v[i] && !found) begin
        lowest_set = IDXW'(i);
        found      = 1'b1;
      end
    end
  endfunction

  // Requests at or above ptr win first; otherwise wrap to the lowest request.
  always_comb begin
    hi_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      hi_mask[i] = (IDXW'(i) >= ptr);
    end
    hi_req  = req & hi_mask;
    win_idx = (|hi_req) ? lowest_set(hi_req) : lowest_set(req);
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    idx_nx   = idx_q;
    oh_nx    = oh_q;
    unique case (state)
      IDLE: begin
        if (|req) begin
          idx_nx          = win_idx;
          oh_nx           = '0;
          oh_nx[win_idx]  = 1'b1;
          state_nx        = GRANT;
        end
      end
      GRANT: begin
        if (gnt_ready) begin
          oh_nx    = '0;
          ptr_nx   = idx_q + IDXW'(1);
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      idx_q <= '0;
      oh_q  <= '0;
      any_q <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      idx_q <= idx_nx;
      oh_q  <= oh_nx;
      any_q <= |req;
    end
  end

  assign gnt_valid  = (state == GRANT);
  assign busy       = (state == BUSY);
  assign gnt_idx    = idx_q;
  assign gnt_onehot = oh_q;
  assign any_req    = any_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler: reset, single grant, full rotation,
// pointer wrap, backpressure and reset while busy.
module tb_rr_grant_scheduler;
  localparam int unsigned N    = 256;
  localparam int unsigned IDXW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic            gnt_valid;
  logic            gnt_ready;
  logic [IDXW-1:0] gnt_idx;
  logic [N-1:0]    gnt_onehot;
  logic            done;
  logic            busy;
  logic            any_req;

  int pass_cnt  = 0;
  int total_cnt = 0;

  rr_grant_scheduler #(.N(N), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt_valid(gnt_valid),
    .gnt_ready(gnt_ready), .gnt_idx(gnt_idx), .gnt_onehot(gnt_onehot),
    .done(done), .busy(busy), .any_req(any_req)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; gnt_ready = 1'b0; done = 1'b0;
    tick(); tick();
    total_cnt++;
    if ({gnt_valid, busy, any_req} !== 3'b000 || gnt_idx !== 8'd0 || gnt_onehot !== '0)
      $display("FAIL reset_state got v=%b b=%b a=%b idx=%0d oh=%h want all zero",
               gnt_valid, busy, any_req, gnt_idx, gnt_onehot);
    else pass_cnt++;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      total_cnt++;
      if ({gnt_valid, busy, any_req} !== 3'b000 || gnt_idx !== 8'd0)
        $display("FAIL idle_noreq cyc%0d got v=%b b=%b a=%b idx=%0d want 0 0 0 0",
                 c, gnt_valid, busy, any_req, gnt_idx);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    logic [N-1:0] exp_oh;
    exp_oh = '0; exp_oh[5] = 1'b1;
    req = '0; req[5] = 1'b1; gnt_ready = 1'b1;
    tick();
    total_cnt++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 8'd5 || gnt_onehot !== exp_oh || any_req !== 1'b1)
      $display("FAIL single_grant got v=%b idx=%0d oh=%h a=%b want v=1 idx=5 oh=%h a=1",
               gnt_valid, gnt_idx, gnt_onehot, any_req, exp_oh);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({gnt_valid, busy} !== 2'b01 || gnt_onehot !== '0 || gnt_idx !== 8'd5)
      $display("FAIL single_busy got v=%b b=%b oh=%h idx=%0d want v=0 b=1 oh=0 idx=5",
               gnt_valid, busy, gnt_onehot, gnt_idx);
    else pass_cnt++;
    req = '0; done = 1'b1;
    tick();
    done = 1'b0;
    total_cnt++;
    if ({gnt_valid, busy} !== 2'b00)
      $display("FAIL single_release got v=%b b=%b want v=0 b=0", gnt_valid, busy);
    else pass_cnt++;
    // ptr should now be 6, so 6 beats 4
    req[4] = 1'b1; req[6] = 1'b1;
    tick();
    total_cnt++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 8'd6)
      $display("FAIL single_ptr6 got v=%b idx=%0d want v=1 idx=6", gnt_valid, gnt_idx);
    else pass_cnt++;
    tick();
    req = '0; done = 1'b1;
    tick();
    done = 1'b0; gnt_ready = 1'b0;
  endtask

  task automatic test_all_rotation();
    logic [N-1:0] exp_oh;
    logic [IDXW-1:0] exp_idx;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req = '1; gnt_ready = 1'b1;
    for (int k = 0; k <= 256; k++) begin
      exp_idx = IDXW'(k % 256);
      exp_oh = '0; exp_oh[exp_idx] = 1'b1;
      tick();
      total_cnt++;
      if (gnt_valid !== 1'b1 || gnt_idx !== exp_idx || gnt_onehot !== exp_oh)
        $display("FAIL rotation k=%0d got v=%b idx=%0d want v=1 idx=%0d",
                 k, gnt_valid, gnt_idx, exp_idx);
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({gnt_valid, busy} !== 2'b01)
        $display("FAIL rotation_busy k=%0d got v=%b b=%b want v=0 b=1", k, gnt_valid, busy);
      else pass_cnt++;
      done = 1'b1;
      tick();
      done = 1'b0;
    end
    req = '0; gnt_ready = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    gnt_ready = 1'b1;
    req = '0; req[253] = 1'b1;
    tick();
    total_cnt++;
    if (gnt_idx !== 8'd253) $display("FAIL wrap_setup got idx=%0d want 253", gnt_idx);
    else pass_cnt++;
    tick(); req = '0; done = 1'b1; tick(); done = 1'b0;
    req[3] = 1'b1; req[200] = 1'b1;
    tick();
    total_cnt++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 8'd3)
      $display("FAIL wrap_ptr254 got v=%b idx=%0d want v=1 idx=3", gnt_valid, gnt_idx);
    else pass_cnt++;
    tick(); done = 1'b1; tick(); done = 1'b0;
    tick();
    total_cnt++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 8'd200)
      $display("FAIL wrap_next got v=%b idx=%0d want v=1 idx=200", gnt_valid, gnt_idx);
    else pass_cnt++;
    tick(); req = '0; done = 1'b1; tick(); done = 1'b0;
    req[255] = 1'b1;
    tick();
    total_cnt++;
    if (gnt_idx !== 8'd255) $display("FAIL wrap_255 got idx=%0d want 255", gnt_idx);
    else pass_cnt++;
    tick(); req = '0; done = 1'b1; tick(); done = 1'b0;
    // ptr wrapped 255 -> 0, so 0 beats 1
    req[0] = 1'b1; req[1] = 1'b1;
    tick();
    total_cnt++;
    if (gnt_idx !== 8'd0) $display("FAIL wrap_to0 got idx=%0d want 0", gnt_idx);
    else pass_cnt++;
    tick(); req = '0; done = 1'b1; tick(); done = 1'b0; gnt_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [N-1:0] exp_oh;
    exp_oh = '0; exp_oh[9] = 1'b1;
    req = '0; req[9] = 1'b1; gnt_ready = 1'b0;
    tick();
    total_cnt++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 8'd9)
      $display("FAIL bp_grant got v=%b idx=%0d want v=1 idx=9", gnt_valid, gnt_idx);
    else pass_cnt++;
    req = '0; req[2] = 1'b1; done = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      total_cnt++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 8'd9 || gnt_onehot !== exp_oh || busy !== 1'b0)
        $display("FAIL bp_hold cyc%0d got v=%b idx=%0d b=%b want v=1 idx=9 b=0",
                 c, gnt_valid, gnt_idx, busy);
      else pass_cnt++;
    end
    done = 1'b0; gnt_ready = 1'b1;
    tick();
    total_cnt++;
    if ({gnt_valid, busy} !== 2'b01 || gnt_idx !== 8'd9)
      $display("FAIL bp_accept got v=%b b=%b idx=%0d want v=0 b=1 idx=9",
               gnt_valid, busy, gnt_idx);
    else pass_cnt++;
    req = '0; done = 1'b1; tick(); done = 1'b0;
    tick();
    total_cnt++;
    if ({gnt_valid, busy} !== 2'b00)
      $display("FAIL bp_ready_idle got v=%b b=%b want v=0 b=0", gnt_valid, busy);
    else pass_cnt++;
    gnt_ready = 1'b0;
  endtask

  task automatic test_reset_busy();
    req = '0; req[7] = 1'b1; gnt_ready = 1'b1;
    tick(); tick();
    total_cnt++;
    if (busy !== 1'b1 || gnt_idx !== 8'd7)
      $display("FAIL rb_setup got b=%b idx=%0d want b=1 idx=7", busy, gnt_idx);
    else pass_cnt++;
    rst_n = 1'b0; req[0] = 1'b1;
    tick();
    total_cnt++;
    if ({gnt_valid, busy, any_req} !== 3'b000 || gnt_idx !== 8'd0 || gnt_onehot !== '0)
      $display("FAIL rb_reset got v=%b b=%b a=%b idx=%0d want all zero",
               gnt_valid, busy, any_req, gnt_idx);
    else pass_cnt++;
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 8'd0 || gnt_onehot[0] !== 1'b1)
      $display("FAIL rb_regrant got v=%b idx=%0d want v=1 idx=0", gnt_valid, gnt_idx);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_rotation();
    test_wrap();
    test_backpressure();
    test_reset_busy();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
